// File: rtl/rom_back.sv
// rom_back: byte-stream READ/WRITE responder in front of a DEPTH x 64-bit memory.
// Requests arrive from a command FIFO and responses go out to a response FIFO.
module rom_back #(
  parameter int unsigned DEPTH     = 256,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       almost_empty,
  output logic       rd_en,
  input  logic [7:0] din,
  input  logic       almost_full,
  output logic       wr_en,
  output logic [7:0] dout,
  output logic       busy
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] HiMask   = ~((32'd1 << (AW + 3)) - 32'd1);
  localparam logic [7:0]  OpRead   = 8'h01;
  localparam logic [7:0]  OpWrite  = 8'h02;
  localparam logic [7:0]  StsOk    = 8'h00;
  localparam logic [7:0]  StsRange = 8'hE1;
  localparam logic [7:0]  StsBadOp = 8'hEE;

  typedef enum logic [2:0] {
    StIdle,
    StOpc,
    StAddr,
    StWdata,
    StExec,
    StResp
  } state_e;

  state_e        state_q;
  logic          start_q;
  logic          pend_q;
  logic          is_write_q;
  logic          long_resp_q;
  logic          zero_data_q;
  logic [3:0]    cnt_q;
  logic [31:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata_q;
  logic [7:0]    dout_q;

  logic          rx_state;
  logic          out_of_range;
  logic          mem_we;
  logic [AW-1:0] word_idx;

  assign rx_state     = (state_q == StOpc) || (state_q == StAddr) || (state_q == StWdata);
  // One outstanding read at most: a new strobe only once the previous byte is captured.
  assign rd_en        = rx_state & ~pend_q & ~almost_empty;
  assign wr_en        = (state_q == StResp) & ~almost_full;
  assign dout         = dout_q;
  assign busy         = (state_q != StIdle);
  assign word_idx     = addr_q[AW+2:3];
  assign out_of_range = |(addr_q & HiMask);
  assign mem_we       = (state_q == StExec) & is_write_q & ~out_of_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      pend_q      <= 1'b0;
      is_write_q  <= 1'b0;
      long_resp_q <= 1'b0;
      zero_data_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dout_q      <= '0;
    end else begin
      // start_q holds off the first read strobe until the second edge after reset.
      start_q <= 1'b1;
      pend_q  <= rd_en;
      case (state_q)
        StIdle: begin
          if (start_q && !almost_empty) begin
            state_q <= StOpc;
          end
        end
        StOpc: begin
          if (pend_q) begin
            cnt_q      <= '0;
            is_write_q <= (din == OpWrite);
            if ((din == OpRead) || (din == OpWrite)) begin
              state_q <= StAddr;
            end else begin
              long_resp_q <= 1'b0;
              dout_q      <= StsBadOp;
              state_q     <= StResp;
            end
          end
        end
        StAddr: begin
          if (pend_q) begin
            addr_q <= {din, addr_q[31:8]};
            if (cnt_q == 4'd3) begin
              cnt_q   <= '0;
              state_q <= is_write_q ? StWdata : StExec;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        StWdata: begin
          if (pend_q) begin
            wdata_q <= {din, wdata_q[63:8]};
            if (cnt_q == 4'd7) begin
              cnt_q   <= '0;
              state_q <= StExec;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        StExec: begin
          long_resp_q <= ~is_write_q;
          zero_data_q <= out_of_range;
          dout_q      <= out_of_range ? StsRange : StsOk;
          cnt_q       <= '0;
          state_q     <= StResp;
        end
        StResp: begin
          if (!almost_full) begin
            if (cnt_q == (long_resp_q ? 4'd8 : 4'd0)) begin
              cnt_q   <= '0;
              dout_q  <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q  <= cnt_q + 4'd1;
              dout_q <= zero_data_q ? 8'h00 : rdata_q[{cnt_q[2:0], 3'b000} +: 8];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read port samples every cycle; the address is stable from EXEC onward, so rdata_q is
  // valid before the first data byte is needed in RESP.
  if (INIT_ZERO) begin : g_mem_zero
    logic [63:0] mem [DEPTH] = '{default: 64'd0};
    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem[word_idx] <= wdata_q;
      end
      rdata_q <= mem[word_idx];
    end
  end else begin : g_mem_raw
    logic [63:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem[word_idx] <= wdata_q;
      end
      rdata_q <= mem[word_idx];
    end
  end

endmodule

// File: doc/rom_back.md
ROM_BACK -- requirements
Module: rom_back

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the number of 64-bit memory words (power of two, 2..4096).
REQ-002 SHALL have parameter INIT_ZERO, default 1; when set, all memory words read 0 after configuration.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port almost_empty, input, 1: the command FIFO has no safe byte to read.
REQ-006 SHALL have port rd_en, output, 1: command FIFO read strobe.
REQ-007 SHALL have port din, input, 8: command byte, valid in the cycle after rd_en.
REQ-008 SHALL have port almost_full, input, 1: the response FIFO cannot safely accept a byte.
REQ-009 SHALL have port wr_en, output, 1: response FIFO write strobe.
REQ-010 SHALL have port dout, output, 8: response byte, qualified by wr_en.
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL act as the responder for the byte-stream read/write protocol. Requests are 5 bytes for READ (opcode 0x01, then address bytes A0..A3) and 13 bytes for WRITE (opcode 0x02, A0..A3, then data bytes D0..D7). All multi-byte fields are little-endian.
REQ-013 SHALL use word index addr[3+log2(DEPTH)-1:3]. Address bits [2:0] SHALL be ignored.
REQ-014 SHALL treat a request as out of range when any address bit at or above 3+log2(DEPTH) is set.
REQ-015 SHALL use FSM states IDLE, OPC, ADDR, WDATA, EXEC, RESP, in that order:
- IDLE -> OPC when almost_empty is low.
- OPC -> ADDR for opcode 0x01 or 0x02.
- OPC -> RESP for any other opcode.
- ADDR -> WDATA after 4 bytes for a WRITE.
- ADDR -> EXEC after 4 bytes for a READ.
- WDATA -> EXEC after 8 bytes.
- EXEC -> RESP after 1 cycle.
- RESP -> IDLE after the last response byte.
REQ-016 SHALL assert rd_en for exactly 1 cycle per byte, and only when almost_empty is low. The byte on din SHALL be captured on the following cycle, and at most one read SHALL be outstanding.
REQ-017 SHALL hold the current state, with no rd_en, while almost_empty is high mid-packet; there is no timeout.
REQ-018 SHALL assert wr_en only when almost_full is low, with dout valid in the same cycle. The FSM SHALL stall in RESP while almost_full is high.
REQ-019 SHALL return a READ response of 9 bytes: status 0x00, then the word D0..D7 LSB first. An out-of-range READ SHALL return status 0xE1 followed by 8 bytes of 0x00.
REQ-020 SHALL return a WRITE response of 1 byte: status 0x00 with the word committed in EXEC, or status 0xE1 with no memory change if out of range.
REQ-021 SHALL return a single byte 0xEE for an unknown opcode and consume no further request bytes.
REQ-022 SHALL allow a READ of an address written by the previous request to return the new data, i.e. no read-after-write hazard.
REQ-023 SHALL accept back-to-back packets with no idle requirement beyond a single IDLE cycle.

Reset
REQ-024 SHALL, while rst_n is low, immediately force the state to IDLE, rd_en=0, wr_en=0, dout=0x00, busy=0, and clear the byte counters.
REQ-025 SHALL NOT alter memory contents on reset. A partially received request SHALL be discarded, and any byte in flight from a pending rd_en SHALL be ignored.
REQ-026 SHALL, after rst_n deasserts, issue the first rd_en no earlier than the second rising clk edge.

Verification
REQ-027 SHALL be verified with: WRITE 02 08 00 00 00 11 22 33 44 55 66 77 88 -> response 00; then READ 01 08 00 00 00 -> 00 11 22 33 44 55 66 77 88.
REQ-028 SHALL be verified with: READ 01 00 00 00 80 (out of range) -> E1 00 00 00 00 00 00 00 00, and no memory write.
REQ-029 SHALL be verified with: opcode 0x7F -> single byte EE; the next byte is parsed as a new opcode.
REQ-030 SHALL be verified with: almost_empty high for 20 cycles mid-address -> no rd_en during the gap, and a correct response afterwards.
REQ-031 SHALL be verified with: almost_full high during RESP for 10 cycles -> no wr_en, then the remaining bytes in order with none lost or duplicated.
REQ-032 SHALL be verified with: rst_n pulsed low after 7 WRITE bytes -> outputs at reset values, no response, the memory word unchanged, and the next clean READ correct.
